// File: rtl/symbol_deser.sv
// symbol_deser: collects N-bit symbols into an M-symbol word and presents it
// with a valid/ready handshake. A flush closes a partial word early, which is
// then presented right-aligned with out_fill giving the number of symbols.
// Optional feature: define SYMBOL_DESER_PARITY_EN to add out_parity, the XOR
// of out_data while a word is presented.
module symbol_deser #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_data,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*M-1:0]           out_data,
  output logic [$clog2(M+1)-1:0]   out_fill
`ifdef SYMBOL_DESER_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int CW = $clog2(M+1);
  localparam int WW = N * M;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   word_q, word_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   countInc;
  logic            inAccept;
  logic            outAccept;

  assign inAccept  = in_valid && in_ready;
  assign outAccept = out_valid && out_ready;
  assign countInc  = count_q + CW'(1);

  // State, word and symbol count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  // Next state: shift symbols in while collecting, present on full or flush
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    case (state_q)
      COLLECT: begin
        if (inAccept) begin
          word_d  = {word_q[WW-N-1:0], in_data};
          count_d = countInc;
        end
        if (count_d == CW'(M)) begin
          state_d = FULL;
        end else if (flush && (count_d != '0)) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (outAccept) begin
          state_d = COLLECT;
          if (inAccept) begin
            word_d  = {{(WW-N){1'b0}}, in_data};
            count_d = CW'(1);
          end else begin
            word_d  = '0;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = COLLECT;
        word_d  = '0;
        count_d = '0;
      end
    endcase
  end

  // Outputs: word and fill are only visible while a word is presented
  always_comb begin
    in_ready  = (state_q == COLLECT) ? 1'b1 : out_ready;
    out_valid = (state_q == FULL);
    out_data  = out_valid ? word_q : '0;
    out_fill  = out_valid ? count_q : '0;
`ifdef SYMBOL_DESER_PARITY_EN
    out_parity = ^out_data;
`endif
  end

endmodule

// File: tb/tb_symbol_deser.sv
// tb_symbol_deser: directed scenarios plus randomized traffic for symbol_deser
// (N=4, M=2), checked cycle by cycle against a queue-based reference model.
// Define SYMBOL_DESER_PARITY_EN to also exercise out_parity.
module tb_symbol_deser;

  localparam int N = 4;
  localparam int M = 2;

  logic                   clk;
  logic                   reset;
  logic                   inValid;
  logic [N-1:0]           inData;
  logic                   inReady;
  logic                   flush;
  logic                   outValid;
  logic                   outReady;
  logic [N*M-1:0]         outData;
  logic [$clog2(M+1)-1:0] outFill;
`ifdef SYMBOL_DESER_PARITY_EN
  logic                   outParity;
`endif

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: symbols of the word being collected, and the word on offer
  int partQ[$];
  int presQ[$];
  bit pres;

  symbol_deser #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_ready  (inReady),
    .flush     (flush),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
`ifdef SYMBOL_DESER_PARITY_EN
    .out_fill  (outFill),
    .out_parity(outParity)
`else
    .out_fill  (outFill)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presented word: first symbol lands in the most significant occupied slot
  function automatic logic [31:0] packPres();
    logic [31:0] acc;
    acc = 0;
    foreach (presQ[i]) acc = acc * (32'd1 << N) + presQ[i];
    return acc;
  endfunction

  task automatic applyStimulus(input logic v, input logic [N-1:0] d, input logic fl,
                               input logic ordy, input logic rst);
    logic [31:0] expData;
    logic        expReady;
    inValid  = v;
    inData   = d;
    flush    = fl;
    outReady = ordy;
    reset    = rst;
    #1;
    expData  = pres ? packPres() : 32'd0;
    expReady = !pres || ordy;
    checkOutput("out_valid", {31'd0, outValid}, {31'd0, pres});
    checkOutput("out_data", {24'd0, outData}, expData);
    checkOutput("out_fill", {30'd0, outFill}, pres ? presQ.size() : 0);
    checkOutput("in_ready", {31'd0, inReady}, {31'd0, expReady});
`ifdef SYMBOL_DESER_PARITY_EN
    checkOutput("out_parity", {31'd0, outParity}, {31'd0, ^expData});
`endif
    @(posedge clk);
    if (rst) begin
      partQ.delete();
      presQ.delete();
      pres = 0;
    end else if (!pres) begin
      if (v) partQ.push_back(int'(d));
      if (partQ.size() == M || (fl && partQ.size() > 0)) begin
        presQ = partQ;
        partQ.delete();
        pres = 1;
      end
    end else if (ordy) begin
      pres = 0;
      presQ.delete();
      if (v) partQ.push_back(int'(d));
    end
    #1;
  endtask

  // Stimulus sequence
  initial begin
    inValid  = 0;
    inData   = '0;
    flush    = 0;
    outReady = 0;
    reset    = 1;
    pres     = 0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus(0, 4'h0, 0, 0, 0);

    // Two symbols form one word, shown one cycle after the second accept
    applyStimulus(1, 4'hA, 0, 1, 0);
    applyStimulus(1, 4'h5, 0, 1, 0);
    checkOutput("basic_word", {24'd0, outData}, 32'hA5);
    checkOutput("basic_fill", {30'd0, outFill}, 32'd2);
    applyStimulus(0, 4'h0, 0, 1, 0);

    // Back-pressure holds the word and refuses input
    applyStimulus(1, 4'h3, 0, 0, 0);
    applyStimulus(1, 4'hC, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 4'hF, 0, 0, 0);
    checkOutput("stall_word", {24'd0, outData}, 32'h3C);
    checkOutput("stall_ready", {31'd0, inReady}, 32'd0);
    applyStimulus(0, 4'h0, 0, 1, 0);

    // Flush of a partial word, then flush with nothing collected
    applyStimulus(1, 4'h7, 0, 0, 0);
    applyStimulus(0, 4'h0, 1, 0, 0);
    checkOutput("flush_word", {24'd0, outData}, 32'h07);
    checkOutput("flush_fill", {30'd0, outFill}, 32'd1);
    applyStimulus(0, 4'h0, 0, 1, 0);
    applyStimulus(0, 4'h0, 1, 1, 0);
    checkOutput("flush_empty", {31'd0, outValid}, 32'd0);

    // Sustained streaming of symbols 1..8
    for (int s = 1; s <= 8; s++) applyStimulus(1, 4'(s), 0, 1, 0);
    applyStimulus(0, 4'h0, 0, 1, 0);

    // Reset with a partial word, then reset while a word is presented
    applyStimulus(1, 4'h9, 0, 1, 0);
    applyStimulus(0, 4'h0, 0, 0, 1);
    checkOutput("rst_part_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_part_ready", {31'd0, inReady}, 32'd1);
    applyStimulus(1, 4'h2, 0, 0, 0);
    applyStimulus(1, 4'h3, 0, 0, 0);
    checkOutput("rst_fresh_word", {24'd0, outData}, 32'h23);
    applyStimulus(0, 4'h0, 0, 0, 1);
    checkOutput("rst_full_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_full_ready", {31'd0, inReady}, 32'd1);
    applyStimulus(1, 4'h4, 0, 0, 0);
    applyStimulus(1, 4'h5, 0, 0, 0);
    checkOutput("rst_next_word", {24'd0, outData}, 32'h45);
    applyStimulus(0, 4'h0, 0, 1, 0);

`ifdef SYMBOL_DESER_PARITY_EN
    // Parity of two known words
    applyStimulus(1, 4'hA, 0, 1, 0);
    applyStimulus(1, 4'h5, 0, 1, 0);
    checkOutput("parity_a5", {31'd0, outParity}, 32'd0);
    applyStimulus(0, 4'h0, 0, 1, 0);
    applyStimulus(1, 4'hA, 0, 1, 0);
    applyStimulus(1, 4'h4, 0, 1, 0);
    checkOutput("parity_a4", {31'd0, outParity}, 32'd1);
    applyStimulus(0, 4'h0, 0, 1, 0);
`endif

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7,
                    4'($urandom),
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) < 6,
                    $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
